// File: rtl/nano_mem_pkg.sv
// Shared address map, state encoding and bus word types for the NanoCPU memory responder.
package nano_mem_pkg;

    typedef logic [15:0] data_t;
    typedef logic [7:0]  addr_t;

    localparam addr_t RAM_TOP     = 8'hFC;
    localparam addr_t ADDR_STATUS = 8'hFD;
    localparam addr_t ADDR_CYCLE  = 8'hFE;
    localparam addr_t ADDR_OUT    = 8'hFF;

    typedef enum logic {
        LD_IDLE = 1'b0,
        LD_LOAD = 1'b1
    } ld_state_t;

endpackage

// File: rtl/nano_out_fifo.sv
// First-word-fall-through FIFO toward the external consumer; a push into a full FIFO
// is still accepted when a pop frees a slot in the same cycle.
module nano_out_fifo #(
    parameter  int DATA_W = 16,
    parameter  int DEPTH  = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              ck,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic [CNT_W-1:0]  count,
    output logic              ovf_pulse
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              full;
    logic              pop_ok;
    logic              push_ok;

    assign empty     = (count == '0);
    assign full      = (count == CNT_W'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign ovf_pulse = push && full && !pop_ok;
    assign head      = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    // Storage is not reset; head is masked to zero while empty.
    always_ff @(posedge ck) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/nano_mem_responder.sv
// NanoCPU memory-side responder: 253-word RAM, streaming preload engine and three
// MMIO words (status, cycle counter, output port feeding a FIFO).
module nano_mem_responder
    import nano_mem_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 8,
    parameter int LOAD_LEN  = 253,
    parameter int OUT_DEPTH = 4
) (
    input  logic              ck,
    input  logic              rst,
    input  logic [ADDR_W-1:0] address,
    input  logic              ce,
    input  logic              we,
    input  logic [DATA_W-1:0] dataW,
    output logic [DATA_W-1:0] dataR,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              out_ovf
);

    localparam int CNT_W     = $clog2(OUT_DEPTH) + 1;
    localparam int RAM_WORDS = int'(RAM_TOP) + 1;

    ld_state_t         state;
    ld_state_t         state_nxt;
    logic [ADDR_W-1:0] ld_ptr;
    logic              ld_accept;
    logic              ld_last;
    logic              cpu_wr;
    logic              fifo_push;
    logic              fifo_empty;
    logic              fifo_ovf;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] ram [RAM_WORDS];
    logic [DATA_W-1:0] cycle_cnt;
    logic [DATA_W-1:0] last_out;
    logic              ovf;

    // The CPU is held in reset during preload, so its bus writes are dropped then.
    assign cpu_wr    = ce && we && (state == LD_IDLE);
    assign ld_accept = ld_valid && ld_ready;
    assign ld_last   = (ld_ptr == ADDR_W'(LOAD_LEN - 1));
    assign fifo_push = cpu_wr && (address == ADDR_W'(ADDR_OUT));

    always_ff @(posedge ck or posedge rst) begin
        if (rst) state <= LD_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE: if (ld_start)             state_nxt = LD_LOAD;
            LD_LOAD: if (ld_accept && ld_last) state_nxt = LD_IDLE;
            default:                           state_nxt = LD_IDLE;
        endcase
    end

    always_comb begin
        ld_busy  = (state == LD_LOAD);
        ld_ready = (state == LD_LOAD);
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst)                    ld_ptr <= '0;
        else if (state == LD_IDLE)  ld_ptr <= '0;
        else if (ld_accept)         ld_ptr <= ld_ptr + ADDR_W'(1);
    end

    always_ff @(posedge ck) begin
        if (ld_accept)
            ram[ld_ptr] <= ld_data;
        else if (cpu_wr && (address <= ADDR_W'(RAM_TOP)))
            ram[address] <= dataW;
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            cycle_cnt <= '0;
            last_out  <= '0;
            ovf       <= 1'b0;
        end else begin
            if (cpu_wr && (address == ADDR_W'(ADDR_CYCLE))) cycle_cnt <= dataW;
            else                                            cycle_cnt <= cycle_cnt + DATA_W'(1);
            if (fifo_push) last_out <= dataW;
            if (cpu_wr && (address == ADDR_W'(ADDR_STATUS))) ovf <= 1'b0;
            else if (fifo_ovf)                               ovf <= 1'b1;
        end
    end

    // Zero-wait-state read path, blanked while the preload owns the memory.
    always_comb begin
        dataR = '0;
        if (state == LD_IDLE) begin
            if (address == ADDR_W'(ADDR_STATUS)) begin
                dataR[DATA_W-1]  = ovf;
                dataR[CNT_W-1:0] = fifo_count;
            end else if (address == ADDR_W'(ADDR_CYCLE)) begin
                dataR = cycle_cnt;
            end else if (address == ADDR_W'(ADDR_OUT)) begin
                dataR = last_out;
            end else begin
                dataR = ram[address];
            end
        end
    end

    nano_out_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (OUT_DEPTH)
    ) u_out_fifo (
        .ck        (ck),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (dataW),
        .pop       (out_ready),
        .head      (out_data),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .ovf_pulse (fifo_ovf)
    );

    assign out_valid = !fifo_empty;
    assign out_ovf   = ovf;

endmodule

// File: tb/tb_nano_mem_responder.sv
// Bench for nano_mem_responder: directed preload/reset sequences, a vector table for
// the FIFO/MMIO rules, and a randomized run against a queue-based reference model.
module tb_nano_mem_responder;
    import nano_mem_pkg::*;

    localparam int LOAD_LEN = 16;
    localparam int DEPTH    = 4;

    logic        ck = 1'b0;
    logic        rst;
    logic [7:0]  address;
    logic        ce, we;
    logic [15:0] dataW;
    logic [15:0] dataR;
    logic        ld_start, ld_valid;
    logic [15:0] ld_data;
    logic        ld_ready, ld_busy;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        out_ovf;

    nano_mem_responder #(
        .DATA_W    (16),
        .ADDR_W    (8),
        .LOAD_LEN  (LOAD_LEN),
        .OUT_DEPTH (DEPTH)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .address   (address),
        .ce        (ce),
        .we        (we),
        .dataW     (dataW),
        .dataR     (dataR),
        .ld_start  (ld_start),
        .ld_valid  (ld_valid),
        .ld_data   (ld_data),
        .ld_ready  (ld_ready),
        .ld_busy   (ld_busy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_ovf   (out_ovf)
    );

    always #5 ck = ~ck;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] ram_m [0:252];
    logic [15:0] q [$];
    logic        ovf_m;
    logic [15:0] last_m;
    logic [15:0] cyc_m;
    bit          cyc_known;

    typedef struct {
        logic [7:0]  addr;
        logic        wr;
        logic [15:0] wdata;
        logic        rdy;
        logic [7:0]  chk;
        logic [15:0] exp_r;
        logic        exp_v;
        logic [15:0] exp_d;
        logic        exp_ovf;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(input logic [7:0] a, input logic w, input logic [15:0] d,
                                input logic r, input logic [7:0] c, input logic [15:0] er,
                                input logic ev, input logic [15:0] ed, input logic eo);
        vec_t v;
        v.addr = a; v.wr = w; v.wdata = d; v.rdy = r; v.chk = c;
        v.exp_r = er; v.exp_v = ev; v.exp_d = ed; v.exp_ovf = eo;
        return v;
    endfunction

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, want %b", nm, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [7:0] a);
        if (a == ADDR_STATUS) return {ovf_m, 10'b0, 5'(q.size())};
        if (a == ADDR_CYCLE)  return cyc_m;
        if (a == ADDR_OUT)    return last_m;
        return ram_m[a];
    endfunction

    task automatic model_reset();
        q.delete();
        ovf_m  = 1'b0;
        last_m = 16'h0000;
    endtask

    task automatic rd(input logic [7:0] a, input logic [15:0] exp, input string nm);
        @(negedge ck);
        address = a;
        #1;
        check16(nm, dataR, exp);
    endtask

    // Streams words base + i*0x111; gap_at drops ld_valid for 3 cycles at that index,
    // stop_after leaves the engine mid-load, poke issues CPU writes while busy.
    task automatic preload(input logic [15:0] base, input int gap_at, input int stop_after,
                           input bit poke, output int busy_cycles, output int accepted);
        int gaps;
        gaps = 0;
        busy_cycles = 0;
        accepted = 0;
        @(negedge ck);
        ld_start = 1'b1;
        @(negedge ck);
        ld_start = 1'b0;
        while (ld_busy && busy_cycles < 1000 && accepted != stop_after) begin
            busy_cycles++;
            if (accepted == gap_at && gaps < 3) begin
                ld_valid = 1'b0;
                gaps++;
            end else begin
                ld_valid = 1'b1;
                ld_data  = 16'(base + accepted * 16'h0111);
            end
            if (poke && busy_cycles == 2) begin
                ce = 1'b1; we = 1'b1; address = 8'h10; dataW = 16'h1234;
            end
            if (poke && busy_cycles == 4) begin
                ce = 1'b1; we = 1'b1; address = ADDR_OUT; dataW = 16'h0BAD;
            end
            #1;
            if (poke && busy_cycles == 2) check16("dataR_during_load", dataR, 16'h0000);
            if (busy_cycles == 1) check1("ld_ready_in_load", ld_ready, 1'b1);
            @(negedge ck);
            if (ld_valid) begin
                ram_m[accepted] = ld_data;
                accepted++;
            end
            ce = 1'b0;
            we = 1'b0;
            ld_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy, acc, r, op;
        bit wr_m, pop_m, full_m;

        rst = 1'b1; address = ADDR_CYCLE; ce = 1'b0; we = 1'b0; dataW = '0;
        ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; out_ready = 1'b0;
        cyc_known = 1'b0;
        #1;
        check1("rst_ld_busy", ld_busy, 1'b0);
        check1("rst_ld_ready", ld_ready, 1'b0);
        check1("rst_out_valid", out_valid, 1'b0);
        check16("rst_out_data", out_data, 16'h0000);
        check1("rst_out_ovf", out_ovf, 1'b0);
        check16("rst_cycle", dataR, 16'h0000);
        repeat (2) @(negedge ck);
        rst = 1'b0;
        model_reset();

        // Full preload with ld_valid held high
        preload(16'h4000, -1, -1, 1'b0, busy, acc);
        check_int("load_busy_cycles", busy, LOAD_LEN);
        check_int("load_accepted", acc, LOAD_LEN);
        check1("load_busy_drop", ld_busy, 1'b0);
        rd(8'h00, 16'h4000, "load_word0");
        rd(8'h01, 16'h4111, "load_word1");
        rd(8'(LOAD_LEN - 1), 16'(16'h4000 + (LOAD_LEN - 1) * 16'h0111), "load_last");

        // Table-driven MMIO / FIFO / counter rules
        tbl[0]  = mk(8'hFF, 1'b1, 16'h0001, 1'b0, 8'hFD, 16'h0001, 1'b1, 16'h0001, 1'b0);
        tbl[1]  = mk(8'hFF, 1'b1, 16'h0002, 1'b0, 8'hFD, 16'h0002, 1'b1, 16'h0001, 1'b0);
        tbl[2]  = mk(8'hFF, 1'b1, 16'h0003, 1'b0, 8'hFD, 16'h0003, 1'b1, 16'h0001, 1'b0);
        tbl[3]  = mk(8'hFF, 1'b1, 16'h0004, 1'b0, 8'hFD, 16'h0004, 1'b1, 16'h0001, 1'b0);
        tbl[4]  = mk(8'hFF, 1'b1, 16'h0005, 1'b0, 8'hFD, 16'h8004, 1'b1, 16'h0001, 1'b1);
        tbl[5]  = mk(8'h00, 1'b0, 16'h0000, 1'b0, 8'hFF, 16'h0005, 1'b1, 16'h0001, 1'b1);
        tbl[6]  = mk(8'hFD, 1'b1, 16'h0000, 1'b0, 8'hFD, 16'h0004, 1'b1, 16'h0001, 1'b0);
        tbl[7]  = mk(8'hFF, 1'b1, 16'h0009, 1'b1, 8'hFD, 16'h0004, 1'b1, 16'h0002, 1'b0);
        tbl[8]  = mk(8'h00, 1'b0, 16'h0000, 1'b1, 8'hFD, 16'h0003, 1'b1, 16'h0003, 1'b0);
        tbl[9]  = mk(8'h00, 1'b0, 16'h0000, 1'b1, 8'hFD, 16'h0002, 1'b1, 16'h0004, 1'b0);
        tbl[10] = mk(8'h00, 1'b0, 16'h0000, 1'b1, 8'hFD, 16'h0001, 1'b1, 16'h0009, 1'b0);
        tbl[11] = mk(8'h00, 1'b0, 16'h0000, 1'b1, 8'hFD, 16'h0000, 1'b0, 16'h0000, 1'b0);
        tbl[12] = mk(8'hFE, 1'b1, 16'hFFFE, 1'b0, 8'hFE, 16'hFFFE, 1'b0, 16'h0000, 1'b0);
        tbl[13] = mk(8'h00, 1'b0, 16'h0000, 1'b0, 8'hFE, 16'hFFFF, 1'b0, 16'h0000, 1'b0);
        tbl[14] = mk(8'h00, 1'b0, 16'h0000, 1'b0, 8'hFE, 16'h0000, 1'b0, 16'h0000, 1'b0);
        tbl[15] = mk(8'h10, 1'b1, 16'h0037, 1'b0, 8'h10, 16'h0037, 1'b0, 16'h0000, 1'b0);
        tbl[16] = mk(8'hFF, 1'b1, 16'h00AB, 1'b0, 8'hFF, 16'h00AB, 1'b1, 16'h00AB, 1'b0);
        @(negedge ck);
        for (int i = 0; i < 17; i++) begin
            address = tbl[i].addr; ce = tbl[i].wr; we = tbl[i].wr;
            dataW = tbl[i].wdata; out_ready = tbl[i].rdy;
            @(negedge ck);
            ce = 1'b0; we = 1'b0;
            address = tbl[i].chk;
            #1;
            check16($sformatf("tbl%0d_dataR", i), dataR, tbl[i].exp_r);
            check1($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].exp_v);
            check16($sformatf("tbl%0d_out_data", i), out_data, tbl[i].exp_d);
            check1($sformatf("tbl%0d_out_ovf", i), out_ovf, tbl[i].exp_ovf);
        end
        out_ready = 1'b0;
        ram_m[16] = 16'h0037;
        q.push_back(16'h00AB);
        last_m = 16'h00AB;

        // Preload with a 3-cycle ld_valid gap and CPU writes attempted while busy
        preload(16'h5000, 5, -1, 1'b1, busy, acc);
        check_int("gap_busy_cycles", busy, LOAD_LEN + 3);
        check_int("gap_accepted", acc, LOAD_LEN);
        rd(8'h05, 16'(16'h5000 + 5 * 16'h0111), "gap_word5");
        rd(8'h06, 16'(16'h5000 + 6 * 16'h0111), "gap_word6");
        rd(8'h10, 16'h0037, "load_blocks_ram_write");
        rd(ADDR_STATUS, 16'h0001, "load_blocks_fifo_push");
        rd(ADDR_OUT, 16'h00AB, "load_blocks_last_out");

        // Asynchronous reset in the middle of a preload
        preload(16'h7000, -1, 5, 1'b0, busy, acc);
        check1("midload_busy", ld_busy, 1'b1);
        #2;
        rst = 1'b1;
        address = ADDR_CYCLE;
        #1;
        check1("async_ld_busy", ld_busy, 1'b0);
        check1("async_out_valid", out_valid, 1'b0);
        check16("async_out_data", out_data, 16'h0000);
        check16("async_cycle", dataR, 16'h0000);
        @(negedge ck);
        rst = 1'b0;
        model_reset();
        for (int a = 0; a <= 16; a++)
            rd(8'(a), ram_m[a], $sformatf("post_reset_ram%0d", a));

        // Randomized bus traffic against the reference model
        for (int s = 0; s < 400; s++) begin
            @(negedge ck);
            ce = 1'b0; we = 1'b0;
            r = $urandom_range(0, 19);
            address = (r <= 16) ? 8'(r) : (r == 17) ? ADDR_STATUS : (r == 18) ? ADDR_CYCLE : ADDR_OUT;
            op = (s == 0) ? 4 : $urandom_range(0, 9);
            out_ready = ($urandom_range(0, 3) == 0);
            dataW = 16'($urandom);
            case (op)
                0, 1, 2: begin ce = 1'b1; we = 1'b1; address = ADDR_OUT; end
                3:       begin ce = 1'b1; we = 1'b1; address = ADDR_STATUS; end
                4:       begin ce = 1'b1; we = 1'b1; address = ADDR_CYCLE; end
                5:       begin ce = 1'b1; we = 1'b1; address = 8'($urandom_range(0, 16)); end
                6:       ce = 1'b1;
                default: ;
            endcase
            #1;
            if (!(address == ADDR_CYCLE && !cyc_known))
                check16("rnd_dataR", dataR, model_read(address));
            check1("rnd_out_valid", out_valid, q.size() != 0);
            check16("rnd_out_data", out_data, (q.size() != 0) ? q[0] : 16'h0000);
            check1("rnd_out_ovf", out_ovf, ovf_m);

            wr_m   = ce && we;
            pop_m  = (q.size() != 0) && out_ready;
            full_m = (q.size() == DEPTH);
            if (wr_m && address == ADDR_CYCLE) begin
                cyc_m = dataW;
                cyc_known = 1'b1;
            end else begin
                cyc_m = cyc_m + 16'h0001;
            end
            if (wr_m && address <= RAM_TOP) ram_m[address] = dataW;
            if (wr_m && address == ADDR_STATUS) ovf_m = 1'b0;
            if (pop_m) void'(q.pop_front());
            if (wr_m && address == ADDR_OUT) begin
                last_m = dataW;
                if (!full_m || pop_m) q.push_back(dataW);
                else                  ovf_m = 1'b1;
            end
        end
        @(negedge ck);
        ce = 1'b0; we = 1'b0; out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
